// File: rtl/flip_select_controller.sv
// -----------------------------------------------------------------------------
// flip_select_controller
//
// Sequences one flip-variable selection for a broken clause. For each valid
// literal it fetches clause-occurrence data, then strobes the break-value
// selector (store literal 0, store literal 1, select) and returns the chosen
// literal through a valid/ready result port.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start_i, clause_id_i,   start handshake (accepted while ready_o=1),
//   lit_valid_i, ready_o    clause index and per-literal valid mask
//   fetch_req_o,            fetch request for literal fetch_lit_o of clause
//   fetch_clause_o,         fetch_clause_o; fetch_ack_i accepts it,
//   fetch_lit_o,            fetch_valid_i flags the returned data
//   fetch_ack_i,
//   fetch_valid_i
//   wren_o, bv_valid_o,     selector write control, break-value valid mask,
//   selected_i              registered selector result
//   done_valid_o,           result handshake carrying the selected literal
//   done_lit_o,
//   done_ready_i
//   abort_i                 cancel the current operation
//   err_o, err_clr_i        sticky error (fetch timeout / empty mask), clear
//   sel_count_o             completed-selection counter (wraps)
// -----------------------------------------------------------------------------
module flip_select_controller #(
    parameter int CLAUSE_BITS = 16,
    parameter int TIMEOUT     = 64,
    parameter int NSAT        = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_i,
    input  logic [CLAUSE_BITS-1:0] clause_id_i,
    input  logic [2:0]             lit_valid_i,
    output logic                   ready_o,
    output logic                   fetch_req_o,
    output logic [CLAUSE_BITS-1:0] fetch_clause_o,
    output logic [1:0]             fetch_lit_o,
    input  logic                   fetch_ack_i,
    input  logic                   fetch_valid_i,
    output logic [1:0]             wren_o,
    output logic [2:0]             bv_valid_o,
    input  logic [1:0]             selected_i,
    output logic                   done_valid_o,
    output logic [1:0]             done_lit_o,
    input  logic                   done_ready_i,
    input  logic                   abort_i,
    output logic                   err_o,
    input  logic                   err_clr_i,
    output logic [15:0]            sel_count_o
);

    if (NSAT != 3) begin : g_bad_nsat
        $error("flip_select_controller: NSAT must be 3");
    end

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("flip_select_controller: TIMEOUT must be in 2..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_SELECT,
        ST_RESULT,
        ST_ERR
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] WR_IDLE = 2'b00;
    localparam logic [1:0] WR_LIT0 = 2'b01;
    localparam logic [1:0] WR_LIT1 = 2'b10;
    localparam logic [1:0] WR_SEL  = 2'b11;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             lit;
    logic [1:0]             lit_nxt;
    logic [1:0]             wren_nxt;
    logic [CLAUSE_BITS-1:0] clause_q;
    logic [2:0]             mask_q;
    logic [15:0]            tmo_cnt;
    logic [15:0]            sel_count_q;
    logic [1:0]             done_lit_q;

    function automatic logic [1:0] lowest_valid(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Literal 2 is never stored: its data goes straight into the select
    // strobe, so a completed fetch of literal 2 bypasses LOAD.
    always_comb begin
        state_nxt = state;
        lit_nxt   = lit;
        if (state != ST_IDLE && abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (lit_valid_i == 3'b000) begin
                            state_nxt = ST_ERR;
                        end else begin
                            state_nxt = ST_FETCH;
                            lit_nxt   = lowest_valid(lit_valid_i);
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_ack_i) state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fetch_valid_i)
                        state_nxt = (lit == 2'd2) ? ST_SELECT : ST_LOAD;
                    else if (tmo_cnt == TMO_LAST)
                        state_nxt = ST_ERR;
                end
                ST_LOAD: begin
                    if (lit == 2'd0 && mask_q[1]) begin
                        state_nxt = ST_FETCH;
                        lit_nxt   = 2'd1;
                    end else if (mask_q[2]) begin
                        state_nxt = ST_FETCH;
                        lit_nxt   = 2'd2;
                    end else begin
                        state_nxt = ST_SELECT;
                    end
                end
                ST_SELECT: state_nxt = ST_RESULT;
                ST_RESULT: begin
                    if (done_ready_i) state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    if (err_clr_i) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wren_nxt = WR_IDLE;
        if (state_nxt == ST_LOAD)
            wren_nxt = (lit_nxt == 2'd0) ? WR_LIT0 : WR_LIT1;
        else if (state_nxt == ST_SELECT)
            wren_nxt = WR_SEL;
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            lit          <= 2'd0;
            clause_q     <= '0;
            mask_q       <= 3'b000;
            tmo_cnt      <= 16'd0;
            sel_count_q  <= 16'd0;
            ready_o      <= 1'b1;
            fetch_req_o  <= 1'b0;
            wren_o       <= WR_IDLE;
            done_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_nxt;
            lit          <= lit_nxt;
            ready_o      <= (state_nxt == ST_IDLE);
            fetch_req_o  <= (state_nxt == ST_FETCH);
            wren_o       <= wren_nxt;
            done_valid_o <= (state_nxt == ST_RESULT);
            err_o        <= (state_nxt == ST_ERR);

            if (state == ST_IDLE && start_i) begin
                clause_q <= clause_id_i;
                mask_q   <= lit_valid_i;
            end

            // Counts WAIT cycles only; any other state (including the FETCH
            // cycle that sees the ack) restarts it.
            if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
            else                  tmo_cnt <= 16'd0;

            if (state == ST_RESULT && done_ready_i && !abort_i)
                sel_count_q <= sel_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_SELECT && state_nxt == ST_RESULT)
            done_lit_q <= selected_i;
    end

    assign fetch_clause_o = clause_q;
    assign fetch_lit_o    = lit;
    assign bv_valid_o     = mask_q;
    assign done_lit_o     = done_lit_q;
    assign sel_count_o    = sel_count_q;

endmodule
